// File: rtl/fetch_unit.sv
// PC and fetch-control stage feeding instruction memory: sequential, redirect or hold next-PC selection.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic [31:0] instr_i,
    input  logic        last_instr_flag_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        halted_o,
    output logic        misaligned_o,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
);

    localparam int unsigned XLEN   = 32;
    localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] MAX_PC = XLEN'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT,
        TRAP
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_seq;
    logic            end_of_prog;
    logic            bad_target;
    logic            seq_overflow;
    logic            fetch_inc;
    logic            stall_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_seq       = pc_q + XLEN'(4);
    assign end_of_prog  = last_instr_flag_i || ((instr_i == 32'hFFFF_FFFF) && (pc_q != '0));
    assign bad_target   = (redirect_target_i[1:0] != 2'b00) || (redirect_target_i > MAX_PC);
    // Widened compare so a PC near the top of the address space cannot wrap past the limit.
    assign seq_overflow = ({1'b0, pc_q} + 33'd4) > {1'b0, MAX_PC};

    // Next-state and next-PC selection; priority order matters inside RUN.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (end_of_prog) begin
                    state_d = HALT;
                end else if (redirect_i && bad_target) begin
                    state_d = TRAP;
                end else if (redirect_i) begin
                    pc_d      = redirect_target_i;
                    fetch_inc = 1'b1;
                end else if (stall_i) begin
                    stall_inc = 1'b1;
                end else if (seq_overflow) begin
                    state_d = HALT;
                end else begin
                    pc_d      = pc_seq;
                    fetch_inc = 1'b1;
                end
            end
            HALT:    state_d = HALT;
            TRAP:    state_d = TRAP;
            default: state_d = BOOT;
        endcase
    end

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_seq;
    assign instr_valid_o = (state_q == RUN);
    assign instr_o       = (state_q == RUN) ? instr_i : NOP;
    assign halted_o      = (state_q == HALT);
    assign misaligned_o  = (state_q == TRAP);

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_inc && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + XLEN'(1);
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`else
    logic unused_perf;
    assign unused_perf   = fetch_inc ^ stall_inc;
    assign fetch_count_o = '0;
    assign stall_count_o = '0;
`endif

endmodule
